prog_clk_divider: RTL
=====================

PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter CW, default 16, divisor and counter width in bits (2..32).
REQ-003 SHALL have parameter DEF_DIV, default 2, divisor loaded into every channel at reset (2..2^CW-1).
REQ-004 SHALL have port clk_in  input  1  single source clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  NCH  per-channel run enable, level-sensitive.
REQ-007 SHALL have port sync  input  1  single-cycle pulse that phase-restarts all running channels.
REQ-008 SHALL have port div_wr  input  1  divisor write strobe, one cycle.
REQ-009 SHALL have port div_ch  input  clog2(NCH) (min 1)  target channel of the write.
REQ-010 SHALL have port div_val  input  CW  new divisor value.
REQ-011 SHALL have port clk_out  output  NCH  registered divided clocks.
REQ-012 SHALL have port tick  output  NCH  registered one-cycle pulse in the last clk_in cycle of each output period.
REQ-013 SHALL have port pend  output  NCH  high while a written divisor waits to be applied.

Function
REQ-014 Each channel SHALL hold an active divisor D, a shadow divisor S, a pending flag P, a counter cnt (CW bits), and a state IDLE or RUN.
REQ-015 Written values below 2 SHALL be stored as 2; div_wr with div_ch >= NCH SHALL be ignored.
REQ-016 In RUN, cnt SHALL count 0..D-1 and wrap to 0, so one output period is exactly D clk_in cycles.
REQ-017 clk_out SHALL be high while cnt < H and low otherwise, where H = ceil(D/2). Odd D gives (D+1)/2 cycles high and (D-1)/2 cycles low. clk_out SHALL be registered together with cnt, with no combinational path to the output.
REQ-018 tick SHALL be high exactly in the cycle where cnt == D-1 in RUN, and low otherwise.
REQ-019 IDLE->RUN: at the edge sampling en=1 in IDLE, the channel SHALL load cnt=0 and clk_out=1. This makes the first output edge 1 cycle after en is sampled.
REQ-020 RUN->IDLE: at the edge sampling en=0, the channel SHALL load cnt=0, clk_out=0 and tick=0 immediately, even mid-period. D, S and P SHALL be unaffected.
REQ-021 A write to a RUN channel SHALL load S and set P. At the wrap edge (cnt == D-1), D SHALL take S and P SHALL clear, so the new period starts with the new divisor. There SHALL be no truncated or stretched period.
REQ-022 A write to an IDLE channel SHALL load D directly and SHALL leave P=0.
REQ-023 A repeated write while P=1 SHALL overwrite S; only the last value SHALL be applied.
REQ-024 When a write lands on the same edge as that channel's wrap, the written value SHALL become D for the new period and P SHALL stay 0.
REQ-025 sync SHALL force every RUN channel to cnt=0 and clk_out=1 at the next edge, and SHALL apply any pending S at that edge (P cleared). IDLE channels SHALL ignore sync.
REQ-026 sync, a wrap and a write on the same edge SHALL resolve as: the written value becomes D, cnt=0, P=0.
REQ-027 An en rise and a write to the same IDLE channel on the same edge SHALL start RUN using the written divisor.
REQ-028 pend SHALL equal P for each channel.
REQ-029 Channels SHALL be fully independent, except for the shared write port and sync.

Reset
REQ-030 While rst=1, every channel SHALL go to IDLE with cnt=0, D=DEF_DIV, S=DEF_DIV, P=0, clk_out=0, tick=0 and pend=0.
REQ-031 rst SHALL override en, sync and div_wr on the same edge, and SHALL abort any period in progress.
REQ-032 Following rst deassertion, channels with en=1 SHALL enter RUN on the first edge that samples rst=0.

Verification
REQ-033 Reset default: rst 3 cycles, then en[0]=1 with DEF_DIV=2 -> clk_out[0] toggles every cycle (1,0,1,0...) and tick[0] is high on every low cycle.
REQ-034 Odd divide: write D=5 to IDLE ch1, then en[1]=1 -> clk_out[1] pattern is 1,1,1,0,0 repeating, and tick[1] is high on the 5th cycle of each period.
REQ-035 Glitch-free reload: ch0 running with D=4; write 6 at cnt=1 -> pend[0]=1 until the wrap; the current period stays 4 cycles, the following periods are 6 cycles (3 high, 3 low), and pend[0] clears at the wrap.
REQ-036 Clamp and bad channel: write div_val=0 to ch2 -> D=2; write with div_ch=NCH -> no register changes.
REQ-037 Sync alignment: ch0 with D=4 and ch1 with D=8, both running at different phases; pulse sync -> both clk_out go high on the same cycle, and the tick of ch0 lands 4 cycles later while the tick of ch1 lands 8 cycles later.
REQ-038 Mid-period reset/disable: drop en[1] at cnt=2 -> next cycle clk_out[1]=0 and no tick; assert rst mid-period on all channels -> all outputs 0 and D back to DEF_DIV.

Source files
------------

// File: rtl/prog_clk_divider.sv
// prog_clk_divider: multi-channel programmable clock divider with glitch-free divisor reload and sync restart
module prog_clk_divider #(
  parameter int NCH = 4,
  parameter int CW = 16,
  parameter int DEF_DIV = 2,
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic           clk_in,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           sync,
  input  logic           div_wr,
  input  logic [CHW-1:0] div_ch,
  input  logic [CW-1:0]  div_val,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pend
);
  logic [CW-1:0] wv;
  assign wv = div_val < CW'(2) ? CW'(2) : div_val;
  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_ch
      logic [CW-1:0] d_q, d_d, s_q, s_d, cnt_q, cnt_d;
      logic [CW:0] half;
      logic p_q, p_d, run_q, run_d, clk_q, clk_d, tick_q, tick_d, wr, wrap;
      // next state; outputs are derived from the next cnt/D so they register together with the counter
      always_comb begin
        wr = div_wr && div_ch == CHW'(i);
        wrap = cnt_q == d_q - 1'b1;
        run_d = en[i];
        cnt_d = '0;
        d_d = d_q;
        s_d = wr ? wv : s_q;
        p_d = p_q;
        if (run_q && en[i]) begin
          if (wrap || sync) begin
            d_d = wr ? wv : p_q ? s_q : d_q;
            p_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            p_d = p_q | wr;
          end
        end else if (run_q) begin
          p_d = p_q | wr;
        end else if (wr) begin
          d_d = wv;
          p_d = 1'b0;
        end
        half = ({1'b0, d_d} + 1'b1) >> 1;
        clk_d = run_d && {1'b0, cnt_d} < half;
        tick_d = run_d && cnt_d == d_d - 1'b1;
      end
      // channel registers with synchronous reset to IDLE and the default divisor
      always_ff @(posedge clk_in) begin
        if (rst) begin
          d_q <= CW'(DEF_DIV);
          s_q <= CW'(DEF_DIV);
          cnt_q <= '0;
          p_q <= 1'b0;
          run_q <= 1'b0;
          clk_q <= 1'b0;
          tick_q <= 1'b0;
        end else begin
          d_q <= d_d;
          s_q <= s_d;
          cnt_q <= cnt_d;
          p_q <= p_d;
          run_q <= run_d;
          clk_q <= clk_d;
          tick_q <= tick_d;
        end
      end
      assign clk_out[i] = clk_q;
      assign tick[i] = tick_q;
      assign pend[i] = p_q;
    end
  endgenerate
endmodule
